// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: frame parity modes,
// receiver FSM encoding, bit-period derivation and a data parity function.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Even parity of up to 9 data bits; narrower data is zero-extended by the caller.
    function automatic logic parity_of(input logic [8:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Show-ahead read port of the UART receive FIFO; master is the receiver,
// slave is the consumer that pops entries.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_frame_err;
    logic                 rd_parity_err;
    logic                 rd_valid;
    logic                 rd_ready;

    modport master (
        output rd_data,
        output rd_frame_err,
        output rd_parity_err,
        output rd_valid,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_frame_err,
        input  rd_parity_err,
        input  rd_valid,
        output rd_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers; the head word reads
// as zero while empty so consumers never see stale storage.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Status decode; a push into a full FIFO is accepted only alongside a real pop.
    always_comb begin
        empty     = (wptr_r == rptr_r);
        full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
        count     = wptr_r - rptr_r;
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        if (empty) begin
            rdata = {WIDTH{1'b0}};
        end else begin
            rdata = mem_r[rptr_r[AW-1:0]];
        end
    end

    // Pointer update.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_r <= {(AW+1){1'b0}};
            rptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample mid-bit majority vote, configurable frame format,
// break detection and a show-ahead FIFO of {frame_err, parity_err, data} entries.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        rx,
    uart_rx_fifo_if.master              rd,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overrun,
    output logic                        break_det,
    input  logic                        clr_err,
    output logic                        rx_busy
);
    import uart_pkg::*;

    localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF = CPB / 2;
    localparam int TW   = $clog2(CPB);
    localparam int EW   = DATA_BITS + 2;

    localparam logic [TW-1:0] T_LOAD  = TW'(CPB - 1);
    localparam logic [TW-1:0] T_SAMP0 = TW'(HALF + 1);
    localparam logic [TW-1:0] T_SAMP1 = TW'(HALF);
    localparam logic [TW-1:0] T_VOTE  = TW'(HALF - 1);
    localparam logic [TW-1:0] T_ZERO  = {TW{1'b0}};
    localparam logic [TW-1:0] T_ONE   = TW'(1);

    localparam parity_e PAR_MODE = parity_e'(PARITY[1:0]);

    localparam logic [2:0] ST_IDLE     = uart_pkg::IDLE;
    localparam logic [2:0] ST_START    = uart_pkg::START;
    localparam logic [2:0] ST_DATA     = uart_pkg::DATA;
    localparam logic [2:0] ST_PARITY   = uart_pkg::PARITY;
    localparam logic [2:0] ST_STOP     = uart_pkg::STOP;
    localparam logic [2:0] ST_BRK_WAIT = uart_pkg::BRK_WAIT;

    localparam logic [2:0] ST_AFTER_DATA = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;

    logic [1:0]           sync_r;
    logic                 rxs_prev_r;
    logic [1:0]           samp_r;
    logic [2:0]           state_r;
    logic [TW-1:0]        timer_r;
    logic [DATA_BITS-1:0] data_r;
    logic [3:0]           bit_cnt_r;
    logic                 par_bit_r;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 stop_cnt_r;
    logic                 push_r;
    logic [EW-1:0]        entry_r;
    logic                 break_r;
    logic                 busy_r;
    logic                 overrun_r;

    logic                 rxs_s;
    logic                 fall_s;
    logic                 vote_s;
    logic                 at_vote_s;
    logic                 at_end_s;
    logic                 ferr_fin_s;
    logic                 exp_par_s;
    logic                 is_break_s;
    logic [2:0]           state_nx_s;
    logic [TW-1:0]        timer_nx_s;
    logic [DATA_BITS-1:0] data_nx_s;
    logic [3:0]           bit_cnt_nx_s;
    logic                 par_bit_nx_s;
    logic                 perr_nx_s;
    logic                 ferr_nx_s;
    logic                 stop_cnt_nx_s;
    logic                 push_nx_s;
    logic [EW-1:0]        entry_nx_s;
    logic                 break_nx_s;

    logic [EW-1:0]        fifo_rdata_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 pop_s;
    logic                 ovr_set_s;

    // Two-flop synchroniser plus edge history; idle-high reset avoids a false start edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_r     <= 2'b11;
            rxs_prev_r <= 1'b1;
        end else begin
            sync_r     <= {sync_r[0], rx};
            rxs_prev_r <= sync_r[1];
        end
    end

    // Capture the first two of the three mid-bit samples; the third is the live input.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            samp_r <= 2'b11;
        end else begin
            if (timer_r == T_SAMP0) begin
                samp_r[0] <= rxs_s;
            end
            if (timer_r == T_SAMP1) begin
                samp_r[1] <= rxs_s;
            end
        end
    end

    // Bit decisions shared by every state.
    always_comb begin
        rxs_s      = sync_r[1];
        fall_s     = rxs_prev_r & ~rxs_s;
        vote_s     = (samp_r[0] & samp_r[1]) | (samp_r[0] & rxs_s) | (samp_r[1] & rxs_s);
        at_vote_s  = (timer_r == T_VOTE);
        at_end_s   = (timer_r == T_ZERO);
        ferr_fin_s = ferr_r | ~vote_s;
        exp_par_s  = parity_of(9'(data_r)) ^ (PAR_MODE == PAR_ODD);
        is_break_s = (data_r == {DATA_BITS{1'b0}}) && ferr_fin_s &&
                     ((PAR_MODE == PAR_NONE) || !par_bit_r);
    end

    // Receiver next-state logic; the frame commits at the last stop vote, not at bit end.
    always_comb begin
        state_nx_s    = state_r;
        data_nx_s     = data_r;
        bit_cnt_nx_s  = bit_cnt_r;
        par_bit_nx_s  = par_bit_r;
        perr_nx_s     = perr_r;
        ferr_nx_s     = ferr_r;
        stop_cnt_nx_s = stop_cnt_r;
        push_nx_s     = 1'b0;
        entry_nx_s    = entry_r;
        break_nx_s    = 1'b0;
        if (state_r == ST_IDLE) begin
            timer_nx_s = timer_r;
        end else if (at_end_s) begin
            timer_nx_s = T_LOAD;
        end else begin
            timer_nx_s = timer_r - T_ONE;
        end

        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nx_s    = ST_START;
                    timer_nx_s    = T_LOAD;
                    data_nx_s     = {DATA_BITS{1'b0}};
                    bit_cnt_nx_s  = 4'd0;
                    par_bit_nx_s  = 1'b0;
                    perr_nx_s     = 1'b0;
                    ferr_nx_s     = 1'b0;
                    stop_cnt_nx_s = 1'b0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (at_vote_s && vote_s) begin
                    state_nx_s = ST_IDLE;
                end else if (at_end_s) begin
                    state_nx_s = ST_DATA;
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (at_vote_s) begin
                    data_nx_s    = {vote_s, data_r[DATA_BITS-1:1]};
                    bit_cnt_nx_s = bit_cnt_r + 4'd1;
                end else if (at_end_s && (bit_cnt_r == 4'(DATA_BITS))) begin
                    state_nx_s = ST_AFTER_DATA;
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (at_vote_s) begin
                    par_bit_nx_s = vote_s;
                    perr_nx_s    = vote_s ^ exp_par_s;
                end else if (at_end_s) begin
                    state_nx_s = ST_STOP;
                end else begin
                    state_nx_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (at_vote_s && (stop_cnt_r == 1'(STOP_BITS - 1))) begin
                    if (is_break_s) begin
                        break_nx_s = 1'b1;
                        state_nx_s = ST_BRK_WAIT;
                    end else begin
                        push_nx_s  = 1'b1;
                        entry_nx_s = {ferr_fin_s, perr_r, data_r};
                        state_nx_s = ST_IDLE;
                    end
                end else if (at_vote_s) begin
                    ferr_nx_s     = ferr_fin_s;
                    stop_cnt_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            ST_BRK_WAIT: begin
                if (rxs_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_BRK_WAIT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Receiver state registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            timer_r    <= T_LOAD;
            data_r     <= {DATA_BITS{1'b0}};
            bit_cnt_r  <= 4'd0;
            par_bit_r  <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            stop_cnt_r <= 1'b0;
            push_r     <= 1'b0;
            entry_r    <= {EW{1'b0}};
            break_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            timer_r    <= timer_nx_s;
            data_r     <= data_nx_s;
            bit_cnt_r  <= bit_cnt_nx_s;
            par_bit_r  <= par_bit_nx_s;
            perr_r     <= perr_nx_s;
            ferr_r     <= ferr_nx_s;
            stop_cnt_r <= stop_cnt_nx_s;
            push_r     <= push_nx_s;
            entry_r    <= entry_nx_s;
            break_r    <= break_nx_s;
            busy_r     <= (state_nx_s != ST_IDLE);
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_r),
        .wdata  (entry_r),
        .pop    (pop_s),
        .rdata  (fifo_rdata_s),
        .count  (count),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    // A push is lost only when the FIFO is full and not draining in the same cycle.
    always_comb begin
        pop_s     = rd.rd_ready & ~fifo_empty_s;
        ovr_set_s = push_r & fifo_full_s & ~pop_s;
    end

    // Sticky overrun; a new drop outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrun_r <= 1'b0;
        end else if (ovr_set_s) begin
            overrun_r <= 1'b1;
        end else if (clr_err) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign rd.rd_data       = fifo_rdata_s[DATA_BITS-1:0];
    assign rd.rd_parity_err = fifo_rdata_s[DATA_BITS];
    assign rd.rd_frame_err  = fifo_rdata_s[DATA_BITS+1];
    assign rd.rd_valid      = ~fifo_empty_s;
    assign overrun          = overrun_r;
    assign break_det        = break_r;
    assign rx_busy          = busy_r;

endmodule
